// File: rtl/mul_fixedpoint_seq.sv
// rtl/mul_fixedpoint_seq.sv - multi-cycle signed Q7.8 shift-add multiplier with saturation and N/V/Z flags
module mul_fixedpoint_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Out,
    output logic                  N,
    output logic                  V,
    output logic                  Z,
    output logic                  busy
);

    // Magnitudes need one extra bit so |-2^(W-1)| is representable.
    localparam int MAG_W = DATA_WIDTH + 1;
    localparam int ACC_W = 2 * DATA_WIDTH + 2;
    localparam int CNT_W = $clog2(DATA_WIDTH + 2);

    localparam logic [ACC_W-1:0] POS_LIMIT = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [ACC_W-1:0] NEG_LIMIT = POS_LIMIT + ACC_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [ACC_W-1:0]  mcand;
    logic [MAG_W-1:0]  mplier;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              sign;

    logic [MAG_W-1:0]      a_ext;
    logic [MAG_W-1:0]      b_ext;
    logic [MAG_W-1:0]      abs_a;
    logic [MAG_W-1:0]      abs_b;
    logic [ACC_W-1:0]      acc_next;
    logic [ACC_W-1:0]      mag;
    logic [DATA_WIDTH-1:0] res_out;
    logic                  res_v;

    // Operand magnitudes and the next shift-add step with its saturated result.
    always_comb begin
        a_ext    = {A[DATA_WIDTH-1], A};
        b_ext    = {B[DATA_WIDTH-1], B};
        abs_a    = a_ext[MAG_W-1] ? (MAG_W'(0) - a_ext) : a_ext;
        abs_b    = b_ext[MAG_W-1] ? (MAG_W'(0) - b_ext) : b_ext;
        acc_next = mplier[0] ? (acc + mcand) : acc;
        mag      = acc_next >> FRAC_BITS;
        res_out  = '0;
        res_v    = 1'b0;
        if (!sign) begin
            if (mag > POS_LIMIT) begin
                res_out = {1'b0, {(DATA_WIDTH-1){1'b1}}};
                res_v   = 1'b1;
            end else begin
                res_out = mag[DATA_WIDTH-1:0];
            end
        end else begin
            if (mag > NEG_LIMIT) begin
                res_out = {1'b1, {(DATA_WIDTH-1){1'b0}}};
                res_v   = 1'b1;
            end else begin
                // A zero magnitude negates to zero, so no negative zero appears.
                res_out = DATA_WIDTH'(0) - mag[DATA_WIDTH-1:0];
            end
        end
    end

    // Control FSM, datapath registers and registered result/flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            sign      <= 1'b0;
            Out       <= '0;
            N         <= 1'b0;
            V         <= 1'b0;
            Z         <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= ACC_W'(abs_a);
                        mplier   <= abs_b;
                        sign     <= A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1];
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_WIDTH)) begin
                        state     <= DONE;
                        Out       <= res_out;
                        N         <= res_out[DATA_WIDTH-1];
                        V         <= res_v;
                        Z         <= (res_out == '0);
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_fixedpoint_seq.sv
// tb/tb_mul_fixedpoint_seq.sv - directed and random checks of mul_fixedpoint_seq against an arithmetic model
module tb_mul_fixedpoint_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Out;
    logic        N;
    logic        V;
    logic        Z;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mul_fixedpoint_seq #(.DATA_WIDTH(16), .FRAC_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out),
        .N         (N),
        .V         (V),
        .Z         (Z),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: exact signed product, magnitude truncated toward zero, then saturated.
    // Returns {Out, N, V, Z}.
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b);
        longint p;
        longint m;
        longint r;
        logic [15:0] o;
        logic v;
        p = longint'($signed(a)) * longint'($signed(b));
        m = ((p < 0) ? -p : p) / 256;
        v = 1'b0;
        if (p >= 0) begin
            if (m > 32767) begin r = 32767; v = 1'b1; end else r = m;
        end else begin
            if (m > 32768) begin r = -32768; v = 1'b1; end else r = -m;
        end
        o = r[15:0];
        return {o, o[15], v, (o == 16'h0000)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full operation: accept, wait for result, optional backpressure, then handshake.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold, input bit check_lat);
        logic [18:0] e;
        int lat;
        e = model(a, b);
        @(negedge clk);
        chk("in_ready_before", in_ready, 1);
        A = a;
        B = b;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (check_lat) chk("latency", lat, 18);
        else           chk("done_seen", out_valid, 1);
        chk("out", Out, e[18:3]);
        chk("n", N, e[2]);
        chk("v", V, e[1]);
        chk("z", Z, e[0]);
        chk("busy_done", busy, 1);
        chk("in_ready_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            A = 16'($urandom);
            B = 16'($urandom);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_out", {Out, N, V, Z}, e);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_dropped", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(negedge clk);
        chk("rst_out", Out, 0);
        chk("rst_flags", {N, V, Z}, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        run_op(16'h0180, 16'h0200, 0, 1'b1);
        chk("basic_value", Out, 16'h0300);
        run_op(16'hFE80, 16'h0200, 0, 1'b1);
        chk("sign_value", Out, 16'hFD00);
        run_op(16'h6400, 16'h0200, 0, 1'b1);
        chk("sat_pos", {Out, V}, {16'h7FFF, 1'b1});
        run_op(16'h8000, 16'hFF00, 0, 1'b1);
        chk("sat_negneg", {Out, V}, {16'h7FFF, 1'b1});
        run_op(16'h8000, 16'h0100, 0, 1'b1);
        chk("neg_limit", {Out, N, V}, {16'h8000, 1'b1, 1'b0});
        run_op(16'h0001, 16'h0001, 0, 1'b1);
        chk("underflow_pos", {Out, N, Z}, {16'h0000, 1'b0, 1'b1});
        run_op(16'hFFFF, 16'h0001, 0, 1'b1);
        chk("underflow_neg", {Out, N, Z}, {16'h0000, 1'b0, 1'b1});

        // Backpressure for 10 cycles, then a second operation right after.
        run_op(16'h0280, 16'hFD00, 10, 1'b1);
        run_op(16'h0180, 16'h0200, 0, 1'b1);

        // Reset 5 cycles into CALC; previous Out is nonzero.
        @(negedge clk);
        A = 16'h0300;
        B = 16'h0200;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out", Out, 0);
        chk("midrst_flags", {N, V, Z}, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_stale_valid", seen, 0);
        chk("in_ready_post_rst", in_ready, 1);
        run_op(16'h0100, 16'h0100, 0, 1'b1);
        chk("post_rst_value", Out, 16'h0100);

        for (int k = 0; k < 20; k++) begin
            run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
